uart_param: RTL and testbench

//  Parametrised single-clock UART: TX and RX engines with an internal baud prescaler.

---
 rtl/uart_param.sv | 264 ++++++++++++++++++++++++++
 tb/tb_uart_param.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/uart_param.sv
// Parametrised single-clock UART: independent TX and RX engines, each with its own
// baud prescaler and oversample tick counter, valid/ready on both data sides.
module uart_param #(
  parameter int DATA_BITS  = 8,
  parameter int CLK_DIV    = 1,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tx_enable,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx_out,
  output logic                 tx_busy,
  input  logic                 rx_enable,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_frame_err,
  output logic                 rx_parity_err,
  output logic                 rx_over_run
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);
  localparam logic [TW-1:0] TICK_LAST  = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] TICK_HALF  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [BW-1:0] DATA_LAST  = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST  = BW'(STOP_BITS - 1);
  localparam bit            HAS_PARITY = (PARITY != 32'sd0);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  // Odd parity makes the total count of ones odd, even parity makes it even.
  function automatic logic parity_bit(input logic [DATA_BITS-1:0] d);
    if (PARITY == 32'sd1) parity_bit = ~^d;
    else                  parity_bit = ^d;
  endfunction

  // ---------------- TX ----------------
  state_t                 tx_state_r, tx_state_s;
  logic [PW-1:0]          tx_presc_r;
  logic [TW-1:0]          tx_tick_r;
  logic [BW-1:0]          tx_bit_r, tx_bit_s;
  logic [DATA_BITS-1:0]   tx_data_r;
  logic                   tx_out_r, tx_out_s, tx_busy_r, tx_busy_s;
  logic                   tx_accept_s, tx_tick_s, tx_bit_done_s;

  assign tx_ready      = (tx_state_r == S_IDLE) && tx_enable;
  assign tx_accept_s   = tx_valid && tx_ready;
  assign tx_tick_s     = (tx_presc_r == PRESC_LAST);
  assign tx_bit_done_s = tx_tick_s && (tx_tick_r == TICK_LAST);
  assign tx_out        = tx_out_r;
  assign tx_busy       = tx_busy_r;

  // TX state, counters and word latch; counters sit at zero while idle so accept restarts them
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state_r <= S_IDLE;
      tx_presc_r <= '0;
      tx_tick_r  <= '0;
      tx_bit_r   <= '0;
      tx_data_r  <= '0;
    end else begin
      tx_state_r <= tx_state_s;
      tx_bit_r   <= tx_bit_s;
      if (tx_accept_s) tx_data_r <= tx_data;
      if (tx_state_r == S_IDLE) begin
        tx_presc_r <= '0;
        tx_tick_r  <= '0;
      end else begin
        tx_presc_r <= tx_tick_s ? '0 : tx_presc_r + PW'(1);
        if (tx_tick_s) tx_tick_r <= (tx_tick_r == TICK_LAST) ? '0 : tx_tick_r + TW'(1);
      end
    end
  end

  // TX next-state
  always_comb begin
    tx_state_s = tx_state_r;
    tx_bit_s   = tx_bit_r;
    case (tx_state_r)
      S_IDLE: begin
        if (tx_accept_s) begin tx_state_s = S_START; tx_bit_s = '0; end
        else             begin tx_state_s = S_IDLE;  tx_bit_s = tx_bit_r; end
      end
      S_START: begin
        if (tx_bit_done_s) begin tx_state_s = S_DATA; tx_bit_s = '0; end
        else               begin tx_state_s = S_START; end
      end
      S_DATA: begin
        if (tx_bit_done_s && (tx_bit_r == DATA_LAST)) begin
          tx_bit_s = '0;
          if (HAS_PARITY) tx_state_s = S_PARITY;
          else            tx_state_s = S_STOP;
        end else if (tx_bit_done_s) begin
          tx_bit_s = tx_bit_r + BW'(1);
        end else begin
          tx_bit_s = tx_bit_r;
        end
      end
      S_PARITY: begin
        if (tx_bit_done_s) begin tx_state_s = S_STOP; tx_bit_s = '0; end
        else               begin tx_state_s = S_PARITY; end
      end
      S_STOP: begin
        if (tx_bit_done_s && (tx_bit_r == STOP_LAST)) begin
          tx_state_s = S_IDLE;
          tx_bit_s   = '0;
        end else if (tx_bit_done_s) begin
          tx_bit_s = tx_bit_r + BW'(1);
        end else begin
          tx_bit_s = tx_bit_r;
        end
      end
      default: begin tx_state_s = S_IDLE; tx_bit_s = '0; end
    endcase
  end

  // TX line value decoded from the upcoming state, so the pin flop changes with the state
  always_comb begin
    tx_busy_s = (tx_state_s != S_IDLE);
    case (tx_state_s)
      S_START:  tx_out_s = 1'b0;
      S_DATA:   tx_out_s = tx_data_r[tx_bit_s];
      S_PARITY: tx_out_s = parity_bit(tx_data_r);
      default:  tx_out_s = 1'b1;
    endcase
  end

  // TX output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_out_r  <= 1'b1;
      tx_busy_r <= 1'b0;
    end else begin
      tx_out_r  <= tx_out_s;
      tx_busy_r <= tx_busy_s;
    end
  end

  // ---------------- RX ----------------
  state_t                 rx_state_r, rx_state_s;
  logic                   rx_d1_r, rx_d2_r;
  logic [PW-1:0]          rx_presc_r;
  logic [TW-1:0]          rx_tick_r;
  logic [BW-1:0]          rx_bit_r, rx_bit_s;
  logic [DATA_BITS-1:0]   rx_shift_r, rx_data_r;
  logic                   rx_par_r, rx_valid_r, rx_ferr_r, rx_perr_r, rx_orun_r;
  logic                   rx_tick_s, rx_sample_s, rx_deliver_s;

  assign rx_tick_s    = (rx_presc_r == PRESC_LAST);
  assign rx_sample_s  = rx_tick_s &&
                        (rx_tick_r == ((rx_state_r == S_START) ? TICK_HALF : TICK_LAST));
  assign rx_deliver_s = rx_enable && rx_sample_s && (rx_state_r == S_STOP);
  assign rx_data       = rx_data_r;
  assign rx_valid      = rx_valid_r;
  assign rx_frame_err  = rx_ferr_r;
  assign rx_parity_err = rx_perr_r;
  assign rx_over_run   = rx_orun_r;

  // Synchroniser, RX state and sampling counters; the half-bit start sample re-phases the tick counter
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_d1_r    <= 1'b1;
      rx_d2_r    <= 1'b1;
      rx_state_r <= S_IDLE;
      rx_presc_r <= '0;
      rx_tick_r  <= '0;
      rx_bit_r   <= '0;
      rx_shift_r <= '0;
      rx_par_r   <= 1'b0;
    end else begin
      rx_d1_r    <= rx_in;
      rx_d2_r    <= rx_d1_r;
      rx_state_r <= rx_state_s;
      rx_bit_r   <= rx_bit_s;
      if (rx_state_r == S_IDLE) begin
        rx_presc_r <= '0;
        rx_tick_r  <= '0;
      end else begin
        rx_presc_r <= rx_tick_s ? '0 : rx_presc_r + PW'(1);
        if (rx_sample_s)    rx_tick_r <= '0;
        else if (rx_tick_s) rx_tick_r <= rx_tick_r + TW'(1);
      end
      if (rx_sample_s && (rx_state_r == S_DATA))   rx_shift_r <= {rx_d2_r, rx_shift_r[DATA_BITS-1:1]};
      if (rx_sample_s && (rx_state_r == S_PARITY)) rx_par_r   <= rx_d2_r;
    end
  end

  // RX next-state
  always_comb begin
    rx_state_s = rx_state_r;
    rx_bit_s   = rx_bit_r;
    if (!rx_enable) begin
      rx_state_s = S_IDLE;
      rx_bit_s   = '0;
    end else begin
      case (rx_state_r)
        S_IDLE: begin
          if (!rx_d2_r) begin rx_state_s = S_START; rx_bit_s = '0; end
          else          begin rx_state_s = S_IDLE; end
        end
        S_START: begin
          if (rx_sample_s && rx_d2_r)  rx_state_s = S_IDLE;
          else if (rx_sample_s)        rx_state_s = S_DATA;
          else                         rx_state_s = S_START;
        end
        S_DATA: begin
          if (rx_sample_s && (rx_bit_r == DATA_LAST)) begin
            rx_bit_s = '0;
            if (HAS_PARITY) rx_state_s = S_PARITY;
            else            rx_state_s = S_STOP;
          end else if (rx_sample_s) begin
            rx_bit_s = rx_bit_r + BW'(1);
          end else begin
            rx_bit_s = rx_bit_r;
          end
        end
        S_PARITY: begin
          if (rx_sample_s) rx_state_s = S_STOP;
          else             rx_state_s = S_PARITY;
        end
        S_STOP: begin
          if (rx_sample_s) rx_state_s = S_IDLE;
          else             rx_state_s = S_STOP;
        end
        default: begin rx_state_s = S_IDLE; rx_bit_s = '0; end
      endcase
    end
  end

  // RX delivery and consumer handshake; a new word beats a same-cycle handshake
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_data_r  <= '0;
      rx_valid_r <= 1'b0;
      rx_ferr_r  <= 1'b0;
      rx_perr_r  <= 1'b0;
      rx_orun_r  <= 1'b0;
    end else if (rx_deliver_s) begin
      rx_data_r  <= rx_shift_r;
      rx_valid_r <= 1'b1;
      rx_ferr_r  <= ~rx_d2_r;
      rx_perr_r  <= HAS_PARITY && (rx_par_r != parity_bit(rx_shift_r));
      rx_orun_r  <= rx_valid_r && !rx_ready;
    end else if (rx_valid_r && rx_ready) begin
      rx_valid_r <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_param.sv
// Directed bench for uart_param (8 data bits, CLK_DIV=2, OVERSAMPLE=4, even parity, 1 stop).
module tb_uart_param;
  logic       clk = 1'b0;
  logic       reset, tx_enable, tx_valid, tx_ready, tx_out, tx_busy;
  logic [7:0] tx_data, rx_data;
  logic       rx_enable, rx_in, rx_valid, rx_ready;
  logic       rx_frame_err, rx_parity_err, rx_over_run;
  logic       loop_en, rx_drive;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;
  assign rx_in = loop_en ? tx_out : rx_drive;

  uart_param #(.DATA_BITS(8), .CLK_DIV(2), .OVERSAMPLE(4), .PARITY(2), .STOP_BITS(1)) dut (
    .clk(clk), .reset(reset),
    .tx_enable(tx_enable), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_out(tx_out), .tx_busy(tx_busy),
    .rx_enable(rx_enable), .rx_in(rx_in), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .rx_frame_err(rx_frame_err), .rx_parity_err(rx_parity_err),
    .rx_over_run(rx_over_run)
  );

  typedef struct {
    logic [7:0] data;
    logic       bad_par;
    logic       stop;
    logic       exp_perr;
    logic       exp_ferr;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Drives one serial frame (start, 8 data LSB first, parity, stop) then 16 idle clks.
  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
    logic [10:0] bits;
    bits = {stop, par, d, 1'b0};
    for (int i = 0; i < 11; i++) begin
      rx_drive = bits[i];
      repeat (8) @(negedge clk);
    end
    rx_drive = 1'b1;
    repeat (16) @(negedge clk);
  endtask

  task automatic consume();
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    vec_t        vecs[5];
    logic [10:0] lb_bits;
    int          busy_cnt;

    vecs[0] = '{8'h3C, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[1] = '{8'h55, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[2] = '{8'h96, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{8'h01, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{8'h80, 1'b1, 1'b1, 1'b1, 1'b0};

    reset = 1'b1; tx_enable = 1'b1; tx_valid = 1'b0; tx_data = 8'h00;
    rx_enable = 1'b1; rx_ready = 1'b0; loop_en = 1'b0; rx_drive = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("rst_tx_out",   32'(tx_out), 32'd1);
    chk("rst_tx_ready", 32'(tx_ready), 32'd1);
    chk("rst_tx_busy",  32'(tx_busy), 32'd0);
    chk("rst_rx_valid", 32'(rx_valid), 32'd0);
    chk("rst_rx_data",  32'(rx_data), 32'd0);
    chk("rst_ferr",     32'(rx_frame_err), 32'd0);
    chk("rst_perr",     32'(rx_parity_err), 32'd0);
    chk("rst_orun",     32'(rx_over_run), 32'd0);

    // Loopback 0xA5: start, A5 LSB first, even parity 0, stop
    lb_bits = {1'b1, 1'b0, 8'hA5, 1'b0};
    loop_en = 1'b1;
    tx_data = 8'hA5; tx_valid = 1'b1;
    busy_cnt = 0;
    for (int c = 0; c < 96; c++) begin
      @(negedge clk);
      if (c == 0) tx_valid = 1'b0;
      if (tx_busy) busy_cnt++;
      if ((c % 8 == 3) && (c / 8 < 11)) chk($sformatf("lb_bit%0d", c / 8), 32'(tx_out), 32'(lb_bits[c / 8]));
    end
    chk("lb_busy_clks", 32'(busy_cnt), 32'd88);
    chk("lb_tx_ready", 32'(tx_ready), 32'd1);
    for (int n = 0; n < 200 && !rx_valid; n++) @(negedge clk);
    chk("lb_rx_valid", 32'(rx_valid), 32'd1);
    chk("lb_rx_data",  32'(rx_data), 32'hA5);
    chk("lb_flags",    32'({rx_frame_err, rx_parity_err, rx_over_run}), 32'd0);
    consume();
    chk("lb_consumed", 32'(rx_valid), 32'd0);
    loop_en = 1'b0;

    // Table of bench-driven frames
    for (int v = 0; v < 5; v++) begin
      send_frame(vecs[v].data, (^vecs[v].data) ^ vecs[v].bad_par, vecs[v].stop);
      chk($sformatf("v%0d_valid", v), 32'(rx_valid), 32'd1);
      chk($sformatf("v%0d_data", v),  32'(rx_data), 32'(vecs[v].data));
      chk($sformatf("v%0d_perr", v),  32'(rx_parity_err), 32'(vecs[v].exp_perr));
      chk($sformatf("v%0d_ferr", v),  32'(rx_frame_err), 32'(vecs[v].exp_ferr));
      chk($sformatf("v%0d_orun", v),  32'(rx_over_run), 32'd0);
      consume();
      chk($sformatf("v%0d_consumed", v), 32'(rx_valid), 32'd0);
    end

    // Overrun: two unread words
    send_frame(8'h11, 1'b0, 1'b1);
    send_frame(8'h22, 1'b0, 1'b1);
    chk("ov_valid", 32'(rx_valid), 32'd1);
    chk("ov_data",  32'(rx_data), 32'h22);
    chk("ov_orun",  32'(rx_over_run), 32'd1);
    consume();
    chk("ov_consumed", 32'(rx_valid), 32'd0);
    chk("ov_data_hold", 32'(rx_data), 32'h22);
    send_frame(8'h33, 1'b0, 1'b1);
    chk("ov_clear_orun", 32'(rx_over_run), 32'd0);
    chk("ov_clear_data", 32'(rx_data), 32'h33);
    consume();

    // rx_enable dropped mid-frame: partial word discarded, outputs held
    begin
      logic [10:0] bits;
      bits = {1'b1, 1'b1, 8'h44, 1'b0};
      for (int i = 0; i < 11; i++) begin
        if (i == 4) rx_enable = 1'b0;
        rx_drive = bits[i];
        repeat (8) @(negedge clk);
      end
      rx_drive = 1'b1;
      repeat (16) @(negedge clk);
      rx_enable = 1'b1;
      repeat (40) @(negedge clk);
    end
    chk("en_valid", 32'(rx_valid), 32'd0);
    chk("en_data",  32'(rx_data), 32'h33);

    // False start: 2-tick low pulse
    rx_drive = 1'b0;
    repeat (4) @(negedge clk);
    rx_drive = 1'b1;
    repeat (100) @(negedge clk);
    chk("glitch_valid", 32'(rx_valid), 32'd0);

    // tx_enable low mid-frame: frame completes, no new accept
    tx_data = 8'h0F; tx_valid = 1'b1;
    @(negedge clk);
    tx_enable = 1'b0;
    chk("txen_busy_mid", 32'(tx_busy), 32'd1);
    repeat (100) @(negedge clk);
    chk("txen_busy_end", 32'(tx_busy), 32'd0);
    chk("txen_ready",    32'(tx_ready), 32'd0);
    chk("txen_out",      32'(tx_out), 32'd1);
    tx_valid = 1'b0; tx_enable = 1'b1;
    @(negedge clk);

    // Reset mid-TX
    tx_data = 8'h00; tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    repeat (20) @(negedge clk);
    chk("mid_tx_busy_pre", 32'(tx_busy), 32'd1);
    chk("mid_tx_out_pre",  32'(tx_out), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_tx_out",  32'(tx_out), 32'd1);
    chk("mid_rst_tx_busy", 32'(tx_busy), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
